// File: rtl/mux2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux2_arb_pkg
// Description : Shared state encoding and source identifiers for the
//               two-input round-robin arbiter.
// Revision    : 1.0
// ============================================================================
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic logic other_src(input logic src);
        return (src == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_rr_arbiter_bus.sv
`default_nettype none
// ============================================================================
// Module      : mux_2to1 / mux2_bus
// Description : Single-bit 2:1 select and a WIDTH-bit bus built from it.
// Revision    : 1.0
// ============================================================================
module mux_2to1
    import mux2_arb_pkg::*;
(
    input  logic sel_i,
    input  logic d0_i,
    input  logic d1_i,
    output logic y_o
);

    assign y_o = (sel_i == SRC_B) ? d1_i : d0_i;

endmodule

module mux2_bus #(
    parameter int WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    output logic [WIDTH-1:0] y_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_2to1 u_mux (
            .sel_i (sel_i),
            .d0_i  (d0_i[i]),
            .d1_i  (d1_i[i]),
            .y_o   (y_o[i])
        );
    end

endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter
// Description : Packet-aware round-robin arbiter for two valid/ready sources
//               with a registered output beat.
// Revision    : 1.0
// ============================================================================
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    output logic             y_src,
    input  logic             y_ready,
    output logic             sel
);

    arb_state_e       state_q;
    logic             prio_last_q;
    logic             sel_q;
    logic             y_valid_q;
    logic [WIDTH-1:0] y_data_q;
    logic             y_last_q;
    logic             y_src_q;

    logic             load;
    logic             grant_vld;
    logic             grant;
    logic             accept;
    logic [WIDTH:0]   mux_out;

    assign load = !y_valid_q || y_ready;

    // With no requester in IDLE the select parks on its previous value.
    always_comb begin
        grant_vld = 1'b0;
        grant     = sel_q;
        case (state_q)
            LOCK_A: begin
                grant_vld = 1'b1;
                grant     = SRC_A;
            end
            LOCK_B: begin
                grant_vld = 1'b1;
                grant     = SRC_B;
            end
            default: begin
                if (a_valid && b_valid) begin
                    grant_vld = 1'b1;
                    grant     = other_src(prio_last_q);
                end else if (a_valid) begin
                    grant_vld = 1'b1;
                    grant     = SRC_A;
                end else if (b_valid) begin
                    grant_vld = 1'b1;
                    grant     = SRC_B;
                end
            end
        endcase
    end

    assign sel     = grant;
    assign a_ready = load && grant_vld && (grant == SRC_A) && a_valid;
    assign b_ready = load && grant_vld && (grant == SRC_B) && b_valid;
    assign accept  = a_ready || b_ready;

    mux2_bus #(
        .WIDTH (WIDTH + 1)
    ) u_bus (
        .sel_i (sel),
        .d0_i  ({a_last, a_data}),
        .d1_i  ({b_last, b_data}),
        .y_o   (mux_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_last_q <= SRC_B;
            sel_q       <= SRC_A;
            y_valid_q   <= 1'b0;
            y_data_q    <= '0;
            y_last_q    <= 1'b0;
            y_src_q     <= SRC_A;
        end else begin
            sel_q <= sel;
            if (accept) begin
                y_valid_q <= 1'b1;
                y_data_q  <= mux_out[WIDTH-1:0];
                y_last_q  <= mux_out[WIDTH];
                y_src_q   <= sel;
                // Priority rotates only when a whole packet has gone through.
                if (mux_out[WIDTH]) begin
                    state_q     <= IDLE;
                    prio_last_q <= sel;
                end else begin
                    state_q <= (sel == SRC_A) ? LOCK_A : LOCK_B;
                end
            end else if (y_ready) begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_last  = y_last_q;
    assign y_src   = y_src_q;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mux2_rr_arbiter
// Description : Directed scoreboard bench for mux2_rr_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0, b_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0, b_data = '0;
    logic             a_last = 1'b0, b_last = 1'b0;
    logic             a_ready, b_ready;
    logic             y_valid, y_last, y_src, sel;
    logic [WIDTH-1:0] y_data;
    logic             y_ready = 1'b1;

    mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_src   (y_src),
        .y_ready (y_ready),
        .sel     (sel)
    );

    always #5 clk = ~clk;

    // {last, data} per pending source beat; {src, last, data} per expected output
    logic [WIDTH:0]   qa[$];
    logic [WIDTH:0]   qb[$];
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] e;

    logic             a_en = 1'b1, b_en = 1'b1;
    logic             blk_b = 1'b0;
    logic             chk_b_blocked = 1'b0;
    logic             chk_stall = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;
    logic             done = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [WIDTH:0] bt(input logic last, input logic [WIDTH-1:0] d);
        return {last, d};
    endfunction

    function automatic logic [WIDTH+1:0] ex(input logic src, input logic last,
                                            input logic [WIDTH-1:0] d);
        return {src, last, d};
    endfunction

    task automatic drive();
        a_valid = a_en && (qa.size() != 0);
        b_valid = b_en && (qb.size() != 0);
        a_data  = '0;
        a_last  = 1'b0;
        b_data  = '0;
        b_last  = 1'b0;
        if (a_valid) begin
            a_data = qa[0][WIDTH-1:0];
            a_last = qa[0][WIDTH];
        end
        if (b_valid) begin
            b_data = qb[0][WIDTH-1:0];
            b_last = qb[0][WIDTH];
        end
        chk_b_blocked = blk_b && (qa.size() != 0);
    endtask

    task automatic step();
        logic ta, tb;
        @(negedge clk);
        ta = a_ready;
        tb = b_ready;
        @(posedge clk);
        #1;
        if (ta) void'(qa.pop_front());
        if (tb) void'(qb.pop_front());
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || exp_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        qa.delete();
        qb.delete();
        a_en  = 1'b1;
        b_en  = 1'b1;
        blk_b = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor / scoreboard: sole owner of the comparison counters.
    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if ({y_valid, y_last, y_src, sel, y_data} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got valid=%b last=%b src=%b sel=%b data=%h, want all 0",
                         y_valid, y_last, y_src, sel, y_data);
            end
        end else begin
            if (chk_b_blocked) begin
                n_vec++;
                if (b_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b_blocked: b_ready=%b, want 0 while A packet open", b_ready);
                end
            end
            if (chk_stall) begin
                n_vec++;
                if ({a_ready, b_ready} !== 2'b00 || y_valid !== 1'b1 || y_data !== stall_data) begin
                    n_err++;
                    $display("FAIL stall_hold: a_ready=%b b_ready=%b y_valid=%b y_data=%h, want 0 0 1 %h",
                             a_ready, b_ready, y_valid, y_data, stall_data);
                end
            end
            if (y_valid && y_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: src=%b last=%b data=%h, want none",
                             y_src, y_last, y_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({y_src, y_last, y_data} !== e) begin
                        n_err++;
                        $display("FAIL beat: got src=%b last=%b data=%h, want src=%b last=%b data=%h",
                                 y_src, y_last, y_data, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
        end
        if (done) begin
            n_vec++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL missing_beats: %0d outstanding, want 0", exp_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single A beat straight out of reset
        qa.push_back(bt(1'b1, 8'h11));
        exp_q.push_back(ex(1'b0, 1'b1, 8'h11));
        drive();
        drain();

        // Continuous contention with single-beat packets, fresh priority
        do_reset();
        for (int i = 0; i < 3; i++) begin
            qa.push_back(bt(1'b1, 8'hAA));
            qb.push_back(bt(1'b1, 8'hBB));
            exp_q.push_back(ex(1'b0, 1'b1, 8'hAA));
            exp_q.push_back(ex(1'b1, 1'b1, 8'hBB));
        end
        drive();
        drain();

        // Three-beat A packet with B waiting (B completed last, so A wins)
        blk_b = 1'b1;
        qa.push_back(bt(1'b0, 8'h01));
        qa.push_back(bt(1'b0, 8'h02));
        qa.push_back(bt(1'b1, 8'h03));
        qb.push_back(bt(1'b1, 8'hB1));
        exp_q.push_back(ex(1'b0, 1'b0, 8'h01));
        exp_q.push_back(ex(1'b0, 1'b0, 8'h02));
        exp_q.push_back(ex(1'b0, 1'b1, 8'h03));
        exp_q.push_back(ex(1'b1, 1'b1, 8'hB1));
        drive();
        drain();
        blk_b = 1'b0;
        drive();

        // Output backpressure for four cycles with both sources pending
        y_ready = 1'b0;
        qa.push_back(bt(1'b1, 8'hC1));
        qa.push_back(bt(1'b1, 8'hC2));
        qb.push_back(bt(1'b1, 8'hD1));
        qb.push_back(bt(1'b1, 8'hD2));
        exp_q.push_back(ex(1'b0, 1'b1, 8'hC1));
        exp_q.push_back(ex(1'b1, 1'b1, 8'hD1));
        exp_q.push_back(ex(1'b0, 1'b1, 8'hC2));
        exp_q.push_back(ex(1'b1, 1'b1, 8'hD2));
        drive();
        step();
        stall_data = 8'hC1;
        chk_stall  = 1'b1;
        repeat (4) step();
        chk_stall = 1'b0;
        y_ready   = 1'b1;
        drain();

        // Asynchronous reset in the middle of a B packet
        qb.push_back(bt(1'b0, 8'hE1));
        qb.push_back(bt(1'b0, 8'hE2));
        qb.push_back(bt(1'b1, 8'hE3));
        exp_q.push_back(ex(1'b1, 1'b0, 8'hE1));
        drive();
        step();
        step();
        #2;
        do_reset();
        qa.push_back(bt(1'b1, 8'hF1));
        qb.push_back(bt(1'b1, 8'hF2));
        exp_q.push_back(ex(1'b0, 1'b1, 8'hF1));
        exp_q.push_back(ex(1'b1, 1'b1, 8'hF2));
        drive();
        drain();

        // A stalls its own packet for two cycles; B must not sneak in
        blk_b = 1'b1;
        qa.push_back(bt(1'b0, 8'h31));
        qa.push_back(bt(1'b0, 8'h32));
        qa.push_back(bt(1'b1, 8'h33));
        qb.push_back(bt(1'b1, 8'h41));
        exp_q.push_back(ex(1'b0, 1'b0, 8'h31));
        exp_q.push_back(ex(1'b0, 1'b0, 8'h32));
        exp_q.push_back(ex(1'b0, 1'b1, 8'h33));
        exp_q.push_back(ex(1'b1, 1'b1, 8'h41));
        drive();
        step();
        a_en = 1'b0;
        drive();
        repeat (2) step();
        a_en = 1'b1;
        drive();
        drain();
        blk_b = 1'b0;
        drive();

        repeat (2) step();
        done = 1'b1;
    end

endmodule
`default_nettype wire
